// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: segment and anode constants shared by the display scanner
package seg7_scan_driver_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [9:0][6:0] SEG_DIGIT = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                           SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  localparam logic [3:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: BCD to active-low gfedcba segments; non-decimal codes show a dash
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb o_seg = (i_bcd > 4'd9) ? SEG_DASH : SEG_DIGIT[i_bcd];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode multiplexer with per-frame snapshot,
// anti-ghosting blanking and optional leading-zero suppression
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 6000,
  parameter int BLANK_CYC = 240
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_en,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);
  logic [15:0]     r_cnt;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_snap;
  logic [3:0]      r_snap_dp;
  logic            r_snap_lz;
  logic [3:0][3:0] w_live;
  logic            w_term;
  logic            w_snap;
  logic            w_blank;
  logic [3:0]      w_dig;
  logic [3:0]      w_dpen;
  logic            w_lz;
  logic            w_lzhit;
  logic [6:0]      w_dec;
  logic [3:0]      w_an_on;
  assign w_live  = {d3, d2, d1, d0};
  assign w_term  = r_cnt == 16'(SCAN_DIV - 1);
  assign w_snap  = (r_cnt == 16'd0) && (r_idx == 2'd0);
  assign w_blank = r_cnt < 16'(BLANK_CYC);
  // On the snapshot cycle the freshly latched values are used so even a zero-length blank shows the new frame
  assign w_dig   = w_snap ? w_live[r_idx] : r_snap[r_idx];
  assign w_dpen  = w_snap ? dp_en : r_snap_dp;
  assign w_lz    = w_snap ? lz_blank : r_snap_lz;
  assign w_lzhit = w_lz && (r_idx == 2'd3) && (w_dig == 4'd0);
  assign w_an_on = ~(4'b0001 << r_idx);
  bcd_to_seg7 u_dec (
    .i_bcd(w_dig),
    .o_seg(w_dec)
  );
  always_ff @(posedge clk) begin
    if (!res) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap     <= '0;
      r_snap_dp  <= '0;
      r_snap_lz  <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_term ? 16'd0 : r_cnt + 16'd1;
      r_idx      <= w_term ? r_idx + 2'd1 : r_idx;
      r_snap     <= w_snap ? w_live : r_snap;
      r_snap_dp  <= w_snap ? dp_en : r_snap_dp;
      r_snap_lz  <= w_snap ? lz_blank : r_snap_lz;
      frame_tick <= w_snap;
      an         <= w_blank ? AN_OFF : w_an_on;
      seg        <= (w_blank || w_lzhit) ? SEG_BLANK : w_dec;
      dp         <= w_blank || !w_dpen[r_idx];
    end
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the seconds/BCD counters. Takes four BCD digits (digit 0 driven by the seconds counter's s_num, digits 1-3 by neighbouring counters or tied off) and time-multiplexes them onto a 4-digit common-anode 7-segment display. A per-frame snapshot prevents tearing, and there is anti-ghosting blanking and optional leading-zero suppression. Sits between the counter chain and the board pins.

Parameters:
SCAN_DIV, 6000, clk cycles per digit slot (24 MHz / 6000 = 4 kHz slot rate, 1 kHz frame); legal range 4..65535.
BLANK_CYC, 240, cycles at the start of each slot with all anodes off; must be < SCAN_DIV.

Ports:
clk  input  1  system clock, single clock domain
res  input  1  synchronous, active-low reset (sampled only on posedge clk)
d0  input  4  BCD digit 0, rightmost (seconds ones, from s_num)
d1  input  4  BCD digit 1
d2  input  4  BCD digit 2
d3  input  4  BCD digit 3, leftmost
dp_en  input  4  decimal point enable per digit, bit i → digit i
lz_blank  input  1  1 = blank digit 3 when its snapshot value is 0
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  4  anode select, active-low, bit i → digit i
frame_tick  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (res==0 at posedge clk): slot counter=0, digit index=0, snapshot regs=0, an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Reset mid-scan takes effect on the next edge and restarts from digit 0.
- Slot counter counts 0..SCAN_DIV-1 and wraps. At the terminal count the index advances 0→1→2→3→0.
- Snapshot: on the cycle the index wraps 3→0, d0..d3, dp_en and lz_blank are latched together. frame_tick is registered and asserts for exactly one cycle at the same edge. The first snapshot after reset is taken on the first cycle after res deasserts, i.e. slot counter=0 and index=0. Inputs changing mid-frame never alter the current frame.
- Blanking: while slot counter < BLANK_CYC, an=4'b1111, seg=7'h7F and dp=1.
- Otherwise: an has only bit[index] low. seg is decode(snapshot[index]). dp = ~snap_dp_en[index].
- Decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10-15 show dash=0111111.
- Leading-zero blanking: if snap_lz_blank=1, index=3 and snap_d3=0, then seg=7'h7F. The anode still asserts, and dp follows snap_dp_en[3].
- Latency: all outputs are registered. Outputs reflect the counter/index state one clk later. There is no combinational path from inputs to outputs.
- Width: the slot counter is 16 bits. Index is 2 bits and wraps naturally.

Decomposition:
- Shared package/include: SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, the digit 0-9 segment constants, and the active-low anode constant AN_OFF=4'b1111.
- One sub-module: bcd_to_seg7, purely combinational, taking 4-bit BCD in and giving 7-bit active-low segments out. It is instantiated once, on the muxed snapshot digit.
- Counters, snapshot and output registers live in the top.

Test Plan:
(Bench uses SCAN_DIV=8, BLANK_CYC=2; clk period 10 ns; res low for 3 cycles, then high.)
- Reset: hold res=0 → an=1111, seg=7F, dp=1, frame_tick=0 every cycle. Asserting res=0 mid-slot of digit 2 → next edge outputs blank, and the scan restarts at digit 0.
- Basic scan: d3..d0=1,2,3,4, dp_en=0, lz_blank=0 → per slot, 2 blank cycles then an=1110/seg=0011001, then an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001. frame_tick pulses once every 32 cycles.
- Snapshot stability: change d0 from 4 to 7 mid-frame → current frame still shows 4 on digit 0. The next frame after frame_tick shows seg=1111000.
- Invalid BCD: d1=4'hC → digit 1 shows 0111111.
- Leading zero and DP: d3=0, lz_blank=1, dp_en=4'b0010 → digit 3 slot shows an=0111, seg=7F. Digit 1 slot shows dp=0, and all other slots show dp=1. With lz_blank=0, digit 3 shows 1000000.
- Live feed from the seconds counter: drive d0 with s_num stepping 0..9 → digit 0 shows each value's code in the frame after it changes, and 9→0 wraps correctly.
